// File: rtl/regfile_dump_ctrl_pkg.sv
// regfile_dump_ctrl_pkg: shared register-file geometry and dump/clear sequencer states
package regfile_dump_ctrl_pkg;
    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_CLEAR, S_DONE} state_t;
    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
        return ADDR_W'((32'(idx) + 32'd1) % NUM_REGS);
    endfunction
endpackage

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: streams or zeroes a wrapping range of the register file on a start pulse
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_sel,
    input  logic [ADDR_W-1:0] last_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_sel,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_sel,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_sel,
    output logic [DATA_W-1:0] out_data
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, last_q;
    logic              xfer, last_out;

    assign xfer          = out_valid && out_ready;
    assign last_out      = out_sel == last_q;
    assign busy          = state != S_IDLE;
    assign done          = state == S_DONE;
    assign rf_write_en   = state == S_CLEAR;
    assign rf_read_sel   = ptr;
    assign rf_write_sel  = ptr;
    assign rf_write_data = '0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = mode ? S_CLEAR : S_LOAD;
            S_LOAD:  state_nx = S_SEND;
            S_SEND:  if (xfer && last_out) state_nx = S_DONE;
            S_CLEAR: if (ptr == last_q) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ptr runs one index ahead of out_sel so the next word is already on the read port
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ptr    <= first_sel;
                    last_q <= last_sel;
                end
                S_LOAD: begin
                    out_data  <= rf_read_data;
                    out_sel   <= ptr;
                    out_valid <= 1'b1;
                    ptr       <= next_idx(ptr);
                end
                S_SEND: if (xfer) begin
                    if (last_out) out_valid <= 1'b0;
                    else begin
                        out_data <= rf_read_data;
                        out_sel  <= ptr;
                        ptr      <= next_idx(ptr);
                    end
                end
                S_CLEAR: if (ptr != last_q) ptr <= next_idx(ptr);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: scoreboard bench with a register-file model and randomized dump/clear traffic
module tb_regfile_dump_ctrl;
    import regfile_dump_ctrl_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } word_t;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
    logic [ADDR_W-1:0] first_sel = '0, last_sel = '0;
    logic              busy, done, rf_write_en, out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] rf_read_sel, rf_write_sel, out_sel;
    logic [DATA_W-1:0] rf_read_data, rf_write_data, out_data;

    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_sel = '0;
    logic [DATA_W-1:0] cpu_data = '0;
    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [DATA_W-1:0] ref_rf [NUM_REGS];

    word_t             exp_q[$];
    logic [ADDR_W-1:0] wq[$];
    word_t             e;
    logic [ADDR_W-1:0] w;
    int                n_chk = 0, n_fail = 0;
    int                ready_mode = 0;
    logic              stall_en = 1'b0;
    logic [ADDR_W-1:0] stall_sel = '0;
    logic              prev_stall = 1'b0, exp_done_next = 1'b0;
    logic [ADDR_W-1:0] prev_sel;
    logic [DATA_W-1:0] prev_data;

    regfile_dump_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .first_sel(first_sel), .last_sel(last_sel),
        .busy(busy), .done(done),
        .rf_read_sel(rf_read_sel), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, CPU port wins over the sequencer's write port
    assign rf_read_data = regs[rf_read_sel];
    always @(posedge clk) begin
        if (cpu_we) regs[cpu_sel] <= cpu_data;
        else if (rf_write_en) regs[rf_write_sel] <= '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: out_ready = !(stall_en && out_valid && out_sel == stall_sel);
                1: out_ready = 1'($urandom);
                2: out_ready = !out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall    = 1'b0;
            exp_done_next = 1'b0;
        end else begin
            if (exp_done_next || done) check("done_pulse", done, exp_done_next);
            exp_done_next = 1'b0;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_sel", out_sel, prev_sel);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got sel %0d data %0h, none expected", out_sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_sel", out_sel, e.sel);
                    check("word_data", out_data, e.data);
                    if (exp_q.size() == 0) exp_done_next = 1'b1;
                end
            end
            if (rf_write_en) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got sel %0d, none expected", rf_write_sel);
                end else begin
                    w = wq.pop_front();
                    check("write_sel", rf_write_sel, w);
                    check("write_data", rf_write_data, 0);
                    if (wq.size() == 0) exp_done_next = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sel   = out_sel;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int i, input logic [DATA_W-1:0] d);
        cpu_we   = 1'b1;
        cpu_sel  = ADDR_W'(i);
        cpu_data = d;
        tick();
        cpu_we    = 1'b0;
        ref_rf[i] = d;
    endtask

    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) cpu_write(i, DATA_W'(32'h100 + i));
    endtask

    // Expected results follow from the range rule: ((last-first) mod 16)+1 words from first upward
    task automatic issue_op(input logic m, input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        int n, idx;
        n = ((int'(l) - int'(f) + NUM_REGS) % NUM_REGS) + 1;
        for (int k = 0; k < n; k++) begin
            idx = (int'(f) + k) % NUM_REGS;
            if (m) begin
                wq.push_back(ADDR_W'(idx));
                ref_rf[idx] = '0;
            end else exp_q.push_back('{sel: ADDR_W'(idx), data: ref_rf[idx]});
        end
        start     = 1'b1;
        mode      = m;
        first_sel = f;
        last_sel  = l;
        tick();
        start     = 1'b0;
        mode      = 1'($urandom);
        first_sel = ADDR_W'($urandom);
        last_sel  = ADDR_W'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 400) begin
            tick();
            t++;
        end
        check("idle_reached", busy, 0);
        check("words_left", exp_q.size(), 0);
        check("writes_left", wq.size(), 0);
        exp_q.delete();
        wq.delete();
    endtask

    initial begin
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_sel", out_sel, 0);
        check("rst_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_wen", rf_write_en, 0);
        rst = 1'b0;
        preload();

        ready_mode = 0;
        issue_op(1'b0, 4'd2, 4'd5);
        check("lat_edge1_valid", out_valid, 0);
        check("lat_edge1_busy", busy, 1);
        tick();
        check("lat_edge2_valid", out_valid, 1);
        check("lat_first_sel", out_sel, 2);
        wait_idle();

        ready_mode = 2;
        issue_op(1'b0, 4'd14, 4'd1);
        wait_idle();

        ready_mode = 0;
        issue_op(1'b1, 4'd0, 4'd15);
        check("clr_first_wen", rf_write_en, 1);
        wait_idle();
        issue_op(1'b0, 4'd0, 4'd15);
        wait_idle();

        preload();
        issue_op(1'b0, 4'd7, 4'd7);
        start     = 1'b1;
        mode      = 1'b1;
        first_sel = 4'd0;
        last_sel  = 4'd15;
        tick();
        start = 1'b0;
        wait_idle();

        ready_mode = 3;
        issue_op(1'b0, 4'd0, 4'd15);
        repeat (4) tick();
        check("stall_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wen", rf_write_en, 0);
        check("midrst_done", done, 0);
        exp_q.delete();
        ready_mode = 0;
        issue_op(1'b0, 4'd3, 4'd6);
        wait_idle();

        stall_sel = 4'd3;
        stall_en  = 1'b1;
        issue_op(1'b0, 4'd0, 4'd7);
        for (int t = 0; t < 50 && !(out_valid && out_sel == 4'd3); t++) tick();
        check("stall_on_word3", out_sel, 3);
        cpu_write(4, 18'h3FFFF);
        foreach (exp_q[i]) if (exp_q[i].sel == 4'd4) exp_q[i].data = 18'h3FFFF;
        stall_en = 1'b0;
        wait_idle();

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(1, 0) == 1) cpu_write(int'($urandom_range(15, 0)), DATA_W'($urandom));
            ready_mode = int'($urandom_range(2, 0));
            issue_op($urandom_range(3, 0) == 0, ADDR_W'($urandom), ADDR_W'($urandom));
            wait_idle();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
